// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcode, FSM state, datapath op
// encoding and the stall-counter width.
package seq_pkg;

  localparam int unsigned OPC_W   = 3;
  localparam int unsigned STALL_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP      = 3'b000,
    OPC_STALL    = 3'b001,
    OPC_MULT_YD  = 3'b010,
    OPC_MULT_X1D = 3'b011,
    OPC_ADD      = 3'b100,
    OPC_RSVD     = 3'b101,
    OPC_WAIT_SW  = 3'b110,
    OPC_LOAD_X   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_STALL   = 3'd3,
    ST_WAIT_SW = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_IDLE     = 2'd0,
    OP_MULT_YD  = 2'd1,
    OP_MULT_X1D = 2'd2,
    OP_ADD      = 2'd3
  } op_e;

  // Map a datapath opcode to the operation code presented on o_op.
  function automatic op_e opc_to_op(input opcode_e opc);
    case (opc)
      OPC_MULT_YD:  return OP_MULT_YD;
      OPC_MULT_X1D: return OP_MULT_X1D;
      OPC_ADD:      return OP_ADD;
      default:      return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous clear has priority over increment; wraps
// modulo 2^Psize.
module pc_counter #(
  parameter int unsigned Psize = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [Psize-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + Psize'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a zero-latency program memory, decodes
// in the fetch cycle and drives datapath start/op/load-X controls.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned Psize        = 3,
  parameter int unsigned Isize        = 2,
  parameter int unsigned STALL_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sw,
  input  logic [Isize:0]   i_instr,
  input  logic             i_op_done,
  output logic [Psize-1:0] o_address,
  output logic             o_start,
  output logic [1:0]       o_op,
  output logic             o_load_x,
  output logic             o_busy
);

  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES - 1);

  state_e               state, state_nx;
  logic [STALL_W-1:0]   cnt, cnt_nx;
  op_e                  op_q, op_nx;
  op_e                  op_c;
  opcode_e              opc;
  logic                 pc_inc, pc_clr;
  logic                 start_c, load_x_c;
  logic [Psize-1:0]     pc;

  assign opc = opcode_e'(i_instr[OPC_W-1:0]);

  pc_counter #(
    .Psize (Psize)
  ) u_pc (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (pc_clr),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // State register plus the held operation and stall countdown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_IDLE;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op_q  <= op_nx;
    end
  end

  // Next-state, pc control and pulse decode. Pulses depend only on state and
  // the instruction addressed by pc, never on i_sw or i_op_done.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    op_c     = OP_IDLE;
    pc_inc   = 1'b0;
    pc_clr   = 1'b0;
    start_c  = 1'b0;
    load_x_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_sw) begin
          state_nx = ST_RUN;
        end
      end

      ST_RUN: begin
        case (opc)
          OPC_LOAD_X: begin
            load_x_c = 1'b1;
            pc_inc   = 1'b1;
          end
          OPC_MULT_YD, OPC_MULT_X1D, OPC_ADD: begin
            start_c  = 1'b1;
            op_c     = opc_to_op(opc);
            op_nx    = opc_to_op(opc);
            state_nx = ST_WAIT_OP;
          end
          OPC_STALL: begin
            cnt_nx   = STALL_LOAD;
            state_nx = ST_STALL;
          end
          OPC_WAIT_SW: begin
            state_nx = ST_WAIT_SW;
          end
          default: begin
            pc_inc = 1'b1;
          end
        endcase
      end

      // A done pulse in the start cycle lands in RUN and is never seen here.
      ST_WAIT_OP: begin
        op_c = op_q;
        if (i_op_done) begin
          pc_inc   = 1'b1;
          op_nx    = OP_IDLE;
          state_nx = ST_RUN;
        end
      end

      ST_STALL: begin
        if (cnt == '0) begin
          pc_inc   = 1'b1;
          state_nx = ST_RUN;
        end else begin
          cnt_nx = cnt - STALL_W'(1);
        end
      end

      ST_WAIT_SW: begin
        if (!i_sw) begin
          pc_clr   = 1'b1;
          state_nx = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign o_address = pc;
  assign o_start   = start_c;
  assign o_load_x  = load_x_c;
  assign o_op      = op_c;
  assign o_busy    = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(start_c && load_x_c));
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset/idle, full program, stall timing,
// done-in-start-cycle, pc wrap and reset in WAIT_OP.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int unsigned PSIZE = 3;
  localparam int unsigned ISIZE = 2;
  localparam int unsigned STALL = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_sw;
  logic             i_op_done;
  logic [ISIZE:0]   i_instr;
  logic [PSIZE-1:0] o_address;
  logic             o_start;
  logic [1:0]       o_op;
  logic             o_load_x;
  logic             o_busy;

  logic [ISIZE:0]   prog [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  assign i_instr = prog[o_address];

  instr_sequencer #(
    .Psize        (PSIZE),
    .Isize        (ISIZE),
    .STALL_CYCLES (STALL)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sw      (i_sw),
    .i_instr   (i_instr),
    .i_op_done (i_op_done),
    .o_address (o_address),
    .o_start   (o_start),
    .o_op      (o_op),
    .o_load_x  (o_load_x),
    .o_busy    (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 8; i++) prog[i] = OPC_NOP;
  endtask

  task automatic do_reset();
    i_rst_n   = 1'b0;
    i_sw      = 1'b0;
    i_op_done = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cd, nload, nstart, n2, after, to, seen_busy, found, pulses, addr_bad, busy_seen;
    logic [2:0] load_addr;
    logic [1:0] ops [3];

    i_rst_n   = 1'b1;
    i_sw      = 1'b0;
    i_op_done = 1'b0;
    fill_nop();
    #1;

    // Test 1: reset and idle with switch off
    do_reset();
    check("rst_addr", o_address, 0);
    check("rst_busy", o_busy, 0);
    check("rst_op", o_op, 0);
    pulses = 0; addr_bad = 0; busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_start || o_load_x) pulses++;
      if (o_address != 0) addr_bad++;
      if (o_busy) busy_seen++;
    end
    check("t1_pulses", pulses, 0);
    check("t1_addr_moves", addr_bad, 0);
    check("t1_busy", busy_seen, 0);

    // Test 2: full program
    prog[0] = OPC_NOP;     prog[1] = OPC_LOAD_X;   prog[2] = OPC_STALL; prog[3] = OPC_MULT_YD;
    prog[4] = OPC_STALL;   prog[5] = OPC_MULT_X1D; prog[6] = OPC_ADD;   prog[7] = OPC_WAIT_SW;
    do_reset();
    i_sw = 1'b1;
    cd = 0; nload = 0; nstart = 0; seen_busy = 0; to = 1; load_addr = '0;
    for (int i = 0; i < 3; i++) ops[i] = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      i_op_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) i_op_done = 1'b1;
      end
      if (o_busy) seen_busy = 1;
      else if (seen_busy != 0) begin
        to = 0;
        break;
      end
      if (o_load_x) begin
        nload++;
        load_addr = o_address;
      end
      if (o_start) begin
        if (nstart < 3) ops[nstart] = o_op;
        nstart++;
        cd = 4;
      end
      if (o_address == 3'd7) i_sw = 1'b0;
    end
    i_op_done = 1'b0;
    check("t2_timeout", to, 0);
    check("t2_nload", nload, 1);
    check("t2_load_addr", load_addr, 1);
    check("t2_nstart", nstart, 3);
    check("t2_op0", ops[0], 1);
    check("t2_op1", ops[1], 2);
    check("t2_op2", ops[2], 3);
    check("t2_end_addr", o_address, 0);
    check("t2_end_busy", o_busy, 0);

    // Test 3: stall timing at pc=2
    fill_nop();
    prog[2] = OPC_STALL;
    do_reset();
    i_sw = 1'b1;
    n2 = 0; after = 0; to = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_address == 3'd2) n2++;
      else if (n2 > 0) begin
        after = int'(o_address);
        to = 0;
        break;
      end
    end
    check("t3_timeout", to, 0);
    check("t3_cycles_at_2", n2, 3);
    check("t3_next_addr", after, 3);

    // Test 4: done in start cycle is ignored
    fill_nop();
    prog[0] = OPC_ADD;
    do_reset();
    i_sw = 1'b1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_start) begin
        found = 1;
        break;
      end
    end
    check("t4_start_seen", found, 1);
    check("t4_start_op", o_op, 3);
    i_op_done = 1'b1;
    @(negedge i_clk);
    i_op_done = 1'b0;
    check("t4_early_done_ignored", o_address, 0);
    check("t4_op_held", o_op, 3);
    check("t4_no_restart", o_start, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_op_done = 1'b1;
    check("t4_before_done", o_address, 0);
    @(negedge i_clk);
    i_op_done = 1'b0;
    check("t4_after_done_addr", o_address, 1);
    check("t4_after_done_op", o_op, 0);

    // Test 5: pc wrap, switch-off mid-run ignored
    fill_nop();
    do_reset();
    i_sw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check($sformatf("t5_pc%0d", i), o_address, i % 8);
      if (i == 3) i_sw = 1'b0;
    end
    check("t5_still_busy", o_busy, 1);

    // Test 6: reset asserted during WAIT_OP
    fill_nop();
    prog[3] = OPC_MULT_X1D;
    do_reset();
    i_sw = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_start) begin
        found = 1;
        break;
      end
    end
    check("t6_start_seen", found, 1);
    @(negedge i_clk);
    check("t6_wait_op", o_op, 2);
    check("t6_wait_busy", o_busy, 1);
    check("t6_wait_addr", o_address, 3);
    #2;
    i_rst_n = 1'b0;
    i_sw    = 1'b0;
    #1;
    check("t6_async_busy", o_busy, 0);
    check("t6_async_op", o_op, 0);
    check("t6_async_addr", o_address, 0);
    check("t6_async_start", o_start, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_op_done = 1'b1;
    @(negedge i_clk);
    i_op_done = 1'b0;
    check("t6_late_done_addr", o_address, 0);
    check("t6_late_done_busy", o_busy, 0);
    @(negedge i_clk);
    check("t6_idle_hold", o_address, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
